// File: rtl/spi_ram.sv
// spi_ram: byte memory driven by SPI slave command words, with independent auto-wrapping write/read pointers
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       addr_err
);
  localparam logic [ADDR_SIZE:0]   DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(MEM_DEPTH - 1);
  logic                 rv_q;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, addr, wr_nxt, rd_nxt;
  logic [7:0]           mem [MEM_DEPTH];
  logic                 acc, wr_ok, rd_ok, do_wr;
  // accept one command per rx_valid rising edge; pointer range checks and wrapped successors
  always_comb begin
    acc    = rx_valid & ~rv_q;
    addr   = rx_data[ADDR_SIZE-1:0];
    wr_ok  = {1'b0, wr_addr} < DEPTH;
    rd_ok  = {1'b0, rd_addr} < DEPTH;
    wr_nxt = (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
    rd_nxt = (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
    do_wr  = acc && (rx_data[9:8] == 2'b01) && wr_ok;
  end
  // memory array is never reset so contents survive arst_n
  always_ff @(posedge clk)
    if (do_wr) mem[wr_addr] <= rx_data[7:0];
  // command decode, pointer updates and read-back; addr_err is a single-cycle pulse
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      rv_q     <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rv_q     <= rx_valid;
      addr_err <= 1'b0;
      if (acc) begin
        tx_valid <= rx_data[9:8] == 2'b11;
        case (rx_data[9:8])
          2'b00: wr_addr <= addr;
          2'b01: if (wr_ok) wr_addr <= wr_nxt; else addr_err <= 1'b1;
          2'b10: rd_addr <= addr;
          default: begin
            tx_data <= rd_ok ? mem[rd_addr] : '0;
            if (rd_ok) rd_addr <= rd_nxt; else addr_err <= 1'b1;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: scoreboard bench for spi_ram, full-depth instance a and MEM_DEPTH=200 instance b
module tb_spi_ram;
  typedef struct {logic [7:0] d; logic v; logic e;} exp_t;
  logic       clk = 1'b0;
  logic       arst_n;
  logic [9:0] rx_data;
  logic       rv_a, rv_b;
  logic [7:0] txd_a, txd_b;
  logic       txv_a, txv_b, err_a, err_b;
  int         checks = 0, failures = 0;
  exp_t       q[$];
  logic [7:0] mm [2][256];
  int         wp [2], rp [2];
  int         dep [2] = '{256, 200};
  logic [7:0] td [2];
  logic       tv [2];

  spi_ram u_a (.clk(clk), .arst_n(arst_n), .rx_data(rx_data), .rx_valid(rv_a),
               .tx_data(txd_a), .tx_valid(txv_a), .addr_err(err_a));
  spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) u_b (.clk(clk), .arst_n(arst_n), .rx_data(rx_data), .rx_valid(rv_b),
               .tx_data(txd_b), .tx_valid(txv_b), .addr_err(err_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      wp[s] = 0; rp[s] = 0; td[s] = '0; tv[s] = 1'b0;
    end
  endtask

  task automatic predict(input int s, input logic [9:0] w);
    exp_t x;
    x.d = td[s]; x.v = 1'b0; x.e = 1'b0;
    case (w[9:8])
      2'b00: wp[s] = int'(w[7:0]);
      2'b01: if (wp[s] < dep[s]) begin
               mm[s][wp[s]] = w[7:0];
               wp[s] = (wp[s] == dep[s] - 1) ? 0 : wp[s] + 1;
             end else x.e = 1'b1;
      2'b10: rp[s] = int'(w[7:0]);
      default: begin
        x.v = 1'b1;
        if (rp[s] < dep[s]) begin
          x.d = mm[s][rp[s]];
          rp[s] = (rp[s] == dep[s] - 1) ? 0 : rp[s] + 1;
        end else begin
          x.d = '0; x.e = 1'b1;
        end
      end
    endcase
    td[s] = x.d; tv[s] = x.v;
    q.push_back(x);
  endtask

  task automatic compare(input int s, input string tag);
    exp_t x;
    if (q.size() == 0) begin
      check({tag, "_qempty"}, 8'd1, 8'd0);
      return;
    end
    x = q.pop_front();
    check({tag, "_txd"}, s ? txd_b : txd_a, x.d);
    check({tag, "_txv"}, s ? txv_b : txv_a, x.v);
    check({tag, "_err"}, s ? err_b : err_a, x.e);
  endtask

  task automatic cmd(input int s, input logic [9:0] w, input string tag, input int hold = 1);
    predict(s, w);
    @(negedge clk);
    rx_data = w;
    if (s == 0) rv_a = 1'b1; else rv_b = 1'b1;
    @(posedge clk); #1;
    compare(s, tag);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_err"}, s ? err_b : err_a, 8'd0);
      check({tag, "_hold_txv"}, s ? txv_b : txv_a, tv[s]);
    end
    @(negedge clk);
    rv_a = 1'b0; rv_b = 1'b0;
    @(posedge clk); #1;
    check({tag, "_err_clr"}, s ? err_b : err_a, 8'd0);
  endtask

  initial begin
    arst_n = 1'b0; rx_data = '0; rv_a = 1'b0; rv_b = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_txd_a", txd_a, 8'h00);
    check("rst_txv_a", txv_a, 8'h00);
    check("rst_err_a", err_a, 8'h00);
    check("rst_txv_b", txv_b, 8'h00);
    arst_n = 1'b1;
    // write then read
    cmd(0, 10'h00A, "wa10");
    cmd(0, 10'h15C, "wd5c");
    cmd(0, 10'h20A, "ra10");
    cmd(0, 10'h300, "rd10");
    // tx_valid clears on next accepted command; auto-increment and wrap
    cmd(0, 10'h0FF, "waff");
    cmd(0, 10'h111, "wd11");
    cmd(0, 10'h122, "wd22");
    cmd(0, 10'h2FF, "raff");
    cmd(0, 10'h300, "rdff");
    cmd(0, 10'h300, "rd00");
    // level-held rx_valid gives a single write
    cmd(0, 10'h006, "wa6");
    cmd(0, 10'h166, "wd66");
    cmd(0, 10'h005, "wa5");
    cmd(0, 10'h1AA, "wdaa_lvl", 12);
    cmd(0, 10'h205, "ra5");
    cmd(0, 10'h300, "rd5");
    cmd(0, 10'h300, "rd6");
    cmd(0, 10'h1BB, "wdbb");
    cmd(0, 10'h206, "ra6");
    cmd(0, 10'h300, "rd6b");
    // out-of-range on the 200-deep instance
    cmd(1, 10'h0C8, "b_wac8");
    cmd(1, 10'h177, "b_wd77");
    cmd(1, 10'h2C8, "b_rac8");
    cmd(1, 10'h300, "b_rdc8");
    cmd(1, 10'h300, "b_rdc8b");
    cmd(1, 10'h155, "b_wd55");
    // async reset while tx_valid is high, with a read command pending across release
    cmd(0, 10'h20A, "ra10b");
    cmd(0, 10'h300, "rd10b");
    check("pre_rst_txv", txv_a, 8'h01);
    @(negedge clk); #2;
    arst_n = 1'b0;
    rx_data = 10'h300; rv_a = 1'b1;
    #1;
    check("arst_txv", txv_a, 8'h00);
    check("arst_txd", txd_a, 8'h00);
    check("arst_err", err_a, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    predict(0, 10'h300);
    arst_n = 1'b1;
    @(posedge clk); #1;
    compare(0, "rel_rd0");
    @(negedge clk);
    rv_a = 1'b0;
    @(posedge clk); #1;
    check("rel_err_clr", err_a, 8'h00);
    cmd(0, 10'h20A, "ra10c");
    cmd(0, 10'h300, "rd10c");
    cmd(0, 10'h205, "ra5c");
    cmd(0, 10'h300, "rd5c");
    check("q_drained", 8'(q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
